writeback_merge: RTL and testbench

- Writeback stage directly upstream of the register file; owns its single write port (reg_we / destreg_num / write_value).
- Merges two result sources: the single-cycle ALU path (priority) and a long-latency path (loads, mul/div) via valid/ready handshake into a small FIFO.
- Guarantees starvation-free draining of long-latency results and suppresses stale or x0 writes.

---
 rtl/writeback_merge.sv | 118 +++++++++++
 tb/tb_writeback_merge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_merge.sv
// Writeback stage owning the register-file write port: merges single-cycle ALU
// results (priority) with queued long-latency results, with starvation relief.
module writeback_merge #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     stall_alu,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [4:0]               mc_rd,
    input  logic [31:0]              mc_data,
    output logic                     reg_we,
    output logic [4:0]               destreg_num,
    output logic [31:0]              write_value,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Handshakes: a transfer happens on a rising edge where valid is high and
    // the matching ready (mc_ready, or !stall_alu for the ALU) is high.
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             we_q, we_d;
    logic [4:0]       wrd_q, wrd_d;
    logic [31:0]      wdata_q, wdata_d;

    logic empty, alu_wr, push, pop;

    always_comb begin
        empty     = (count_q == '0);
        stall_alu = (starve_q == SW'(STARVE_MAX)) && !empty;
        mc_ready  = (count_q < CW'(DEPTH));
        alu_wr    = alu_valid && !stall_alu && (alu_rd != 5'd0);
        push      = mc_valid && mc_ready;
        pop       = stall_alu || (!alu_wr && !empty);
    end

    always_comb begin
        we_d    = 1'b0;
        wrd_d   = wrd_q;
        wdata_d = wdata_q;
        if (pop) begin
            we_d    = live_q[rd_ptr_q];
            wrd_d   = rd_q[rd_ptr_q];
            wdata_d = data_q[rd_ptr_q];
        end else if (alu_wr) begin
            we_d    = 1'b1;
            wrd_d   = alu_rd;
            wdata_d = alu_data;
        end
    end

    // The ALU result is younger than anything queued, so it kills older writes
    // to the same register, including one arriving this very cycle.
    always_comb begin
        live_d = live_q;
        if (alu_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
            end
        end
        if (push) live_d[wr_ptr_q] = (mc_rd != 5'd0) && !(alu_wr && (mc_rd == alu_rd));
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        starve_d = starve_q;
        if (pop || empty)  starve_d = '0;
        else if (alu_wr)   starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            wrd_q    <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            live_q   <= live_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            wrd_q    <= wrd_d;
            wdata_q  <= wdata_d;
            if (push) begin
                rd_q[wr_ptr_q]   <= mc_rd;
                data_q[wr_ptr_q] <= mc_data;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign reg_we      = we_q;
    assign destreg_num = wrd_q;
    assign write_value = wdata_q;
    assign pending     = count_q;
endmodule

// File: tb/tb_writeback_merge.sv
// Directed plus randomized bench for writeback_merge, checked against a
// queue-based reference model of the writeback rules.
module tb_writeback_merge;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        stall_alu;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_data = '0;
    logic        reg_we;
    logic [4:0]  destreg_num;
    logic [31:0] write_value;
    logic [1:0]  pending;

    writeback_merge #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .stall_alu(stall_alu),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
        .reg_we(reg_we), .destreg_num(destreg_num), .write_value(write_value),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   starve = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        output logic a_acc, output logic m_acc);
        logic stall_e, ready_e, alu_wr, popped, we_e;
        logic [4:0] rd_e;
        logic [31:0] d_e;
        ent_t e;
        int size0;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mc_valid = mv;  mc_rd = mrd;  mc_data = md;
        #1;
        size0   = q.size();
        stall_e = (starve == STARVE_MAX) && (size0 > 0);
        ready_e = (size0 < DEPTH);
        chk("stall_alu", 32'(stall_alu), 32'(stall_e));
        chk("mc_ready", 32'(mc_ready), 32'(ready_e));
        chk("pending", 32'(pending), 32'(size0));
        a_acc  = av && !stall_e;
        alu_wr = a_acc && (ard != 5'd0);
        m_acc  = mv && ready_e;
        we_e = 1'b0; rd_e = '0; d_e = '0; popped = 1'b0;
        if (stall_e || (!alu_wr && size0 > 0)) begin
            e = q.pop_front();
            popped = 1'b1;
            we_e = e.live; rd_e = e.rd; d_e = e.data;
        end else if (alu_wr) begin
            we_e = 1'b1; rd_e = ard; d_e = ad;
        end
        if (alu_wr) foreach (q[i]) if (q[i].rd == ard) q[i].live = 1'b0;
        if (m_acc) begin
            e.live = (mrd != 5'd0) && !(alu_wr && mrd == ard);
            e.rd = mrd; e.data = md;
            q.push_back(e);
        end
        if (popped || size0 == 0) starve = 0;
        else if (alu_wr)          starve++;
        @(posedge clk); #1;
        chk("reg_we", 32'(reg_we), 32'(we_e));
        if (we_e) begin
            chk("destreg_num", 32'(destreg_num), 32'(rd_e));
            chk("write_value", write_value, d_e);
        end
    endtask

    task automatic idle(input int n);
        logic a, m;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a, m);
    endtask

    initial begin
        logic a_acc, m_acc;
        logic av, mv;
        logic [4:0] ard, mrd;
        logic [31:0] ad, md;
        int mc_idx, seen[3];
        bit full_seen;

        // Power-on reset
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_we", 32'(reg_we), 0);
        chk("rst_rd", 32'(destreg_num), 0);
        chk("rst_wv", write_value, 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ready", 32'(mc_ready), 1);
        chk("rst_stall", 32'(stall_alu), 0);

        // ALU-only stream
        step(1, 5, 32'h11, 0, 0, 0, a_acc, m_acc);
        chk("t1_we5", 32'(reg_we), 1); chk("t1_rd5", 32'(destreg_num), 5); chk("t1_v5", write_value, 32'h11);
        step(1, 6, 32'h22, 0, 0, 0, a_acc, m_acc);
        chk("t1_rd6", 32'(destreg_num), 6); chk("t1_v6", write_value, 32'h22);
        step(1, 0, 32'h33, 0, 0, 0, a_acc, m_acc);
        chk("t1_we0", 32'(reg_we), 0);
        step(1, 7, 32'h44, 0, 0, 0, a_acc, m_acc);
        chk("t1_rd7", 32'(destreg_num), 7); chk("t1_v7", write_value, 32'h44);

        // Lone long-latency result
        step(0, 0, 0, 1, 9, 32'hDEADBEEF, a_acc, m_acc);
        chk("t2_pend1", 32'(pending), 1); chk("t2_we_early", 32'(reg_we), 0);
        step(0, 0, 0, 0, 0, 0, a_acc, m_acc);
        chk("t2_we", 32'(reg_we), 1); chk("t2_rd", 32'(destreg_num), 9); chk("t2_v", write_value, 32'hDEADBEEF);

        // Starvation relief
        step(0, 0, 0, 1, 3, 32'h333, a_acc, m_acc);
        for (int i = 0; i < 4; i++) begin
            step(1, 4, 32'h444, 0, 0, 0, a_acc, m_acc);
            chk("t3_alu_rd", 32'(destreg_num), 4);
        end
        chk("t3_stall", 32'(stall_alu), 1);
        step(1, 4, 32'h444, 0, 0, 0, a_acc, m_acc);
        chk("t3_mc_rd", 32'(destreg_num), 3); chk("t3_mc_v", write_value, 32'h333);
        step(1, 4, 32'h444, 0, 0, 0, a_acc, m_acc);
        chk("t3_alu_after", 32'(destreg_num), 4); chk("t3_alu_we", 32'(reg_we), 1);

        // Kill of an older queued write
        step(0, 0, 0, 1, 8, 32'h888, a_acc, m_acc);
        step(1, 8, 32'h55, 0, 0, 0, a_acc, m_acc);
        chk("t4_rd", 32'(destreg_num), 8); chk("t4_v", write_value, 32'h55);
        step(0, 0, 0, 0, 0, 0, a_acc, m_acc);
        chk("t4_dead_we", 32'(reg_we), 0); chk("t4_pend0", 32'(pending), 0);

        // Full FIFO under continuous ALU traffic
        mc_idx = 0; full_seen = 0;
        seen[0] = 0; seen[1] = 0; seen[2] = 0;
        ard = 5'd1; ad = 32'd100;
        for (int k = 0; k < 26; k++) begin
            step(k < 20, ard, ad, mc_idx < 3, 5'(20 + mc_idx), 32'(32'hA0 + mc_idx), a_acc, m_acc);
            if (a_acc) begin ard = 5'(1 + (k % 5)); ad = 32'(100 + k); end
            if (m_acc) mc_idx++;
            if (m_acc && mc_idx == 2 && !full_seen) begin
                full_seen = 1;
                chk("t5_full_ready", 32'(mc_ready), 0);
            end
            if (reg_we && destreg_num >= 20 && destreg_num <= 22) seen[destreg_num - 20]++;
        end
        for (int i = 0; i < 3; i++) chk("t5_once", 32'(seen[i]), 1);
        chk("t5_all_accepted", 32'(mc_idx), 3);

        // Reset mid-operation
        step(0, 0, 0, 1, 12, 32'hC12, a_acc, m_acc);
        step(1, 14, 32'hE14, 1, 13, 32'hD13, a_acc, m_acc);
        chk("t6_pend2", 32'(pending), 2);
        rst = 1'b1;
        alu_valid = 1; alu_rd = 15; alu_data = 32'hF15;
        mc_valid = 1; mc_rd = 16; mc_data = 32'h116;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); starve = 0;
        chk("t6_we", 32'(reg_we), 0);
        chk("t6_pend", 32'(pending), 0);
        chk("t6_ready", 32'(mc_ready), 1);
        chk("t6_stall", 32'(stall_alu), 0);
        idle(2);

        // Randomized traffic; inputs held until accepted
        av = 0; mv = 0; ard = 0; mrd = 0; ad = 0; md = 0;
        a_acc = 1; m_acc = 1;
        for (int k = 0; k < 400; k++) begin
            if (!av || a_acc) begin
                av = ($urandom_range(0, 9) < 7); ard = 5'($urandom_range(0, 7)); ad = $urandom;
            end
            if (!mv || m_acc) begin
                mv = ($urandom_range(0, 9) < 4); mrd = 5'($urandom_range(0, 7)); md = $urandom;
            end
            step(av, ard, ad, mv, mrd, md, a_acc, m_acc);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
